// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: grants one requester at a time, caps each tenure at
// MAX_HOLD cycles and registers the owner's word onto Y with a valid strobe.

module bus_arbiter_rr_lane #(
  parameter int WIDTH = 20
) (
  input  logic             sel,
  input  logic             req,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             xfer
);
  assign q    = sel ? d : '0;
  assign xfer = sel & req;
endmodule

module bus_arbiter_rr #(
  parameter  int WIDTH    = 20,
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] D,
  output logic [N_REQ-1:0]       GNT,
  output logic [IDX_W-1:0]       OWNER,
  output logic [WIDTH-1:0]       Y,
  output logic                   Y_VALID
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                ptr, ptr_nxt, ptr_rel, arb_base, win, owner_nxt;
  logic [HOLD_W-1:0]               hold, hold_nxt;
  logic [N_REQ-1:0]                gnt_nxt, lane_xfer;
  logic [N_REQ-1:0][WIDTH-1:0]     d_lane, lane_q;
  logic [WIDTH-1:0]                y_sel, y_nxt;
  logic                            win_vld, xfer, release_c;

  assign d_lane = D;

  // Each lane masks its word with its own grant bit; the one-hot grant makes
  // the OR of all lanes the owner's word.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    bus_arbiter_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .sel  (GNT[i]),
      .req  (REQ[i]),
      .d    (d_lane[i]),
      .q    (lane_q[i]),
      .xfer (lane_xfer[i])
    );
  end

  always_comb begin
    y_sel = '0;
    for (int i = 0; i < N_REQ; i++) y_sel |= lane_q[i];
  end

  assign xfer      = |lane_xfer;
  assign release_c = (state == GRANT) &&
                     (!REQ[OWNER] || (hold == HOLD_W'(MAX_HOLD)));
  assign ptr_rel   = (OWNER == IDX_W'(N_REQ - 1)) ? '0 : OWNER + IDX_W'(1);
  // On release the search already uses the advanced pointer, so a handover
  // costs no idle cycle.
  assign arb_base  = release_c ? ptr_rel : ptr;

  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(arb_base) + k) % N_REQ;
      if (!win_vld && REQ[idx]) begin
        win_vld = 1'b1;
        win     = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      hold    <= '0;
      GNT     <= '0;
      OWNER   <= '0;
      Y       <= '0;
      Y_VALID <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      hold    <= hold_nxt;
      GNT     <= gnt_nxt;
      OWNER   <= owner_nxt;
      Y       <= y_nxt;
      Y_VALID <= xfer;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   if (release_c && !win_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt   = GNT;
    owner_nxt = OWNER;
    hold_nxt  = hold;
    ptr_nxt   = ptr;
    y_nxt     = xfer ? y_sel : Y;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          owner_nxt    = win;
          hold_nxt     = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_nxt = ptr_rel;
          if (win_vld) begin
            gnt_nxt      = '0;
            gnt_nxt[win] = 1'b1;
            owner_nxt    = win;
            hold_nxt     = HOLD_W'(1);
          end else begin
            gnt_nxt  = '0;
            hold_nxt = '0;
          end
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: begin
        gnt_nxt  = '0;
        hold_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: reset, single tenure, full rotation,
// sole-requester re-grant, early handover and mid-tenure reset.

module tb_bus_arbiter_rr;
  localparam int W = 20;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] D;
  logic [N-1:0]   GNT;
  logic [1:0]     OWNER;
  logic [W-1:0]   Y;
  logic           Y_VALID;

  int errors = 0;
  int checks = 0;

  bus_arbiter_rr #(.WIDTH(W), .N_REQ(N), .MAX_HOLD(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
    .GNT(GNT), .OWNER(OWNER), .Y(Y), .Y_VALID(Y_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    D[i*W +: W] = v;
  endtask

  logic [W-1:0] words [4];
  int           own;

  initial begin
    words[0] = 20'h11111; words[1] = 20'h22222;
    words[2] = 20'h33333; words[3] = 20'h44444;

    // Reset held with all requests active
    RST = 1'b1; REQ = 4'b1111;
    for (int i = 0; i < N; i++) set_d(i, W'($urandom));
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_gnt", GNT, 4'b0000);
      chk("rst_y", Y, 0);
      chk("rst_yv", Y_VALID, 0);
      chk("rst_owner", OWNER, 0);
    end
    RST = 1'b0;
    tick();
    chk("post_rst_gnt", GNT, 4'b0001);
    chk("post_rst_owner", OWNER, 0);

    // Drop to idle (pointer -> 1), then single tenure by requester 2
    REQ = 4'b0000;
    tick();
    chk("idle_gnt", GNT, 4'b0000);
    REQ = 4'b0100; set_d(2, 20'hABCDE);
    tick();
    chk("t2_c1_gnt", GNT, 4'b0100);
    chk("t2_c1_yv", Y_VALID, 0);
    tick();
    chk("t2_c2_gnt", GNT, 4'b0100);
    chk("t2_c2_y", Y, 20'hABCDE);
    chk("t2_c2_yv", Y_VALID, 1);
    tick();
    chk("t2_c3_gnt", GNT, 4'b0100);
    chk("t2_c3_yv", Y_VALID, 1);
    REQ = 4'b0000;
    tick();
    chk("t2_c4_gnt", GNT, 4'b0000);
    chk("t2_c4_yv", Y_VALID, 0);
    chk("t2_c4_y_hold", Y, 20'hABCDE);
    chk("t2_idle_owner", OWNER, 2);
    // Pointer now 3: requester 3 beats requester 0
    REQ = 4'b1001;
    tick();
    chk("t2_ptr3_gnt", GNT, 4'b1000);
    chk("t2_ptr3_owner", OWNER, 3);
    REQ = 4'b0000;
    tick();
    chk("t2_idle2_gnt", GNT, 4'b0000);

    // Full rotation, pointer at 0, MAX_HOLD=8 per tenure
    for (int i = 0; i < N; i++) set_d(i, words[i]);
    REQ = 4'b1111;
    for (int n = 1; n <= 33; n++) begin
      tick();
      own = ((n - 1) / 8) % 4;
      chk($sformatf("rot_gnt_%0d", n), GNT, 32'(1 << own));
      if (n >= 2) begin
        chk($sformatf("rot_y_%0d", n), Y, words[((n - 2) / 8) % 4]);
        chk($sformatf("rot_yv_%0d", n), Y_VALID, 1);
      end
    end

    // Sole requester 1 re-wins on every hold expiry
    REQ = 4'b0000;
    tick();
    chk("t4_idle_gnt", GNT, 4'b0000);
    set_d(1, 20'h5A5A5);
    REQ = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("sole_gnt_%0d", n), GNT, 4'b0010);
      if (n >= 2) chk($sformatf("sole_yv_%0d", n), Y_VALID, 1);
    end
    chk("sole_y", Y, 20'h5A5A5);

    // Owner 0 drops early while requester 3 waits
    REQ = 4'b0000;
    tick();
    REQ = 4'b0001;
    tick();
    chk("t5_gnt0", GNT, 4'b0001);
    set_d(3, 20'h3C3C3);
    REQ = 4'b1001;
    tick();
    chk("t5_k_gnt", GNT, 4'b0001);
    chk("t5_k_yv", Y_VALID, 1);
    REQ = 4'b1000;
    tick();
    chk("t5_k1_gnt", GNT, 4'b1000);
    chk("t5_k1_yv", Y_VALID, 0);
    tick();
    chk("t5_k2_yv", Y_VALID, 1);
    chk("t5_k2_y", Y, 20'h3C3C3);

    // Reset in the middle of owner 2's tenure
    REQ = 4'b0000;
    tick();
    REQ = 4'b0100;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk($sformatf("t6_gnt_%0d", n), GNT, 4'b0100);
    end
    RST = 1'b1; REQ = 4'b1111;
    tick();
    chk("t6_rst_gnt", GNT, 4'b0000);
    chk("t6_rst_y", Y, 0);
    chk("t6_rst_yv", Y_VALID, 0);
    chk("t6_rst_owner", OWNER, 0);
    RST = 1'b0;
    tick();
    chk("t6_post_gnt", GNT, 4'b0001);
    chk("t6_post_owner", OWNER, 0);
    chk("t6_post_yv", Y_VALID, 0);
    tick();
    chk("t6_post2_y", Y, words[0]);
    chk("t6_post2_yv", Y_VALID, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
